// File: rtl/fetch_sequencer.sv
// Fetch sequencer: fills one decode register (ir) from a combinational instruction memory under HALTED/RUN/FAULT control.
// Latency: one cycle from pc to ir; first fetch one cycle after start or redirect. Backpressure: ir, ir_pc, pc hold while ir_valid && !ir_ready.
// Build option PC_BOUND_EN: a fetch attempted at pc >= MEM_DEPTH faults instead of fetching; otherwise pc simply wraps.
module fetch_sequencer #(
  parameter int                  PC_WIDTH          = 8,
  parameter int                  INSTRUCTION_WIDTH = 16,
  parameter int                  MEM_DEPTH         = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0,
  parameter logic [3:0]          HALT_OPCODE       = 4'hF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [PC_WIDTH-1:0]          pc,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  input  logic                         start,
  input  logic                         redirect,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  output logic [INSTRUCTION_WIDTH-1:0] ir,
  output logic [PC_WIDTH-1:0]          ir_pc,
  output logic                         ir_valid,
  input  logic                         ir_ready,
  output logic                         halted,
  output logic                         fault
);

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t                         state, state_nxt;
  logic [PC_WIDTH-1:0]            pc_nxt, ir_pc_nxt;
  logic [INSTRUCTION_WIDTH-1:0]   ir_nxt;
  logic                           ir_valid_nxt;
  logic                           fetch_try, out_of_bounds, fetch, is_halt;

  assign fetch_try = (state == RUN) && !redirect && (!ir_valid || ir_ready);

`ifdef PC_BOUND_EN
  assign out_of_bounds = 32'(pc) >= 32'(MEM_DEPTH);
`else
  assign out_of_bounds = 1'b0;
`endif

  assign fetch   = fetch_try && !out_of_bounds;
  assign is_halt = (instruction[INSTRUCTION_WIDTH-1 -: 4] == HALT_OPCODE);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_valid_nxt = ir_valid && !ir_ready;

    if (fetch) begin
      ir_nxt       = instruction;
      ir_pc_nxt    = pc;
      ir_valid_nxt = 1'b1;
      pc_nxt       = pc + 1'b1;
      if (is_halt) state_nxt = HALTED;
    end else if (fetch_try) begin
      // Only reachable with the bound check: refuse the fetch and park pc.
      state_nxt = FAULT;
    end

    case (state)
      HALTED: begin
        if (start) state_nxt = RUN;
        if (redirect) begin
          pc_nxt       = redirect_pc;
          ir_valid_nxt = 1'b0;
        end
      end
      RUN: begin
        if (redirect) begin
          pc_nxt       = redirect_pc;
          ir_valid_nxt = 1'b0;
        end
      end
      FAULT: begin
        // A pending ir keeps draining through the handshake here.
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = HALTED;
        end
      end
      default: state_nxt = HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HALTED;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
      ir_valid <= ir_valid_nxt;
    end
  end

  assign halted = (state == HALTED);

`ifdef PC_BOUND_EN
  assign fault = (state == FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, all checked against a cycle model of the fetch rules.
module tb_fetch_sequencer;
  localparam int PW = 8;
  localparam int IW = 16;
  localparam int MD = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          redirect = 1'b0;
  logic          ir_ready = 1'b1;
  logic [PW-1:0] redirect_pc = '0;
  logic [PW-1:0] pc, ir_pc;
  logic [IW-1:0] instruction, ir;
  logic          ir_valid, halted, fault;

  logic [IW-1:0] mem [256];
  assign instruction = mem[pc];

  int errors = 0;
  int checks = 0;

  // Reference state: mode 0 = halted, 1 = running, 2 = faulted.
  logic [PW-1:0] m_pc, m_ir_pc;
  logic [IW-1:0] m_ir;
  logic          m_v;
  int            m_mode;

  fetch_sequencer #(
    .PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .MEM_DEPTH(MD), .RESET_PC('0), .HALT_OPCODE(4'hF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction), .start(start),
    .redirect(redirect), .redirect_pc(redirect_pc), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_ir = '0; m_ir_pc = '0; m_v = 1'b0; m_mode = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'(m_pc));
    check({tag, "_ir"}, 32'(ir), 32'(m_ir));
    check({tag, "_ir_pc"}, 32'(ir_pc), 32'(m_ir_pc));
    check({tag, "_ir_valid"}, 32'(ir_valid), 32'(m_v));
    check({tag, "_halted"}, 32'(halted), 32'(m_mode == 0));
    check({tag, "_fault"}, 32'(fault), 32'(m_mode == 2));
  endtask

  // One clock: work out what the rules say happens at this edge, let the edge happen, compare.
  task automatic tick(input string tag);
    logic [PW-1:0] npc = m_pc;
    logic [PW-1:0] nirpc = m_ir_pc;
    logic [IW-1:0] nir = m_ir;
    logic          nv = m_v;
    int            nmode = m_mode;
    logic          want_fetch;
    want_fetch = (m_mode == 1) && !redirect && (!m_v || ir_ready);
    if (m_v && ir_ready) nv = 1'b0;
`ifdef PC_BOUND_EN
    if (want_fetch && int'(m_pc) >= MD) begin
      want_fetch = 1'b0;
      nmode = 2;
    end
`endif
    if (want_fetch) begin
      nir = mem[m_pc];
      nirpc = m_pc;
      nv = 1'b1;
      npc = m_pc + 8'd1;
      if (mem[m_pc] >> 12 == 16'hF) nmode = 0;
    end
    if (redirect) begin
      npc = redirect_pc;
      if (m_mode == 2) nmode = 0;
      else nv = 1'b0;
    end
    if (m_mode == 0 && start) nmode = 1;
    @(posedge clk);
    #1;
    m_pc = npc; m_ir = nir; m_ir_pc = nirpc; m_v = nv; m_mode = nmode;
    check_model(tag);
  endtask

  task automatic load_linear();
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
  endtask

  initial begin
    logic [IW-1:0] w;
    load_linear();
    mem[5] = 16'hF000;
    model_reset();

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check_model("reset");
    check("reset_halted", 32'(halted), 32'd1);
    rst_n = 1'b1;

    // Start, then four back-to-back fetches
    start = 1'b1; tick("start");
    check("start_no_fetch", 32'(ir_valid), 32'd0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("seq");
      check("seq_ir_pc", 32'(ir_pc), 32'(i));
      check("seq_ir_valid", 32'(ir_valid), 32'd1);
    end

    // Backpressure hold on word 1
    redirect = 1'b1; redirect_pc = 8'd1; tick("redir1");
    redirect = 1'b0; tick("fetch1");
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall_ir", 32'(ir), 32'h1001);
      check("stall_ir_pc", 32'(ir_pc), 32'd1);
      check("stall_pc", 32'(pc), 32'd2);
    end
    ir_ready = 1'b1; tick("resume");
    check("resume_ir_pc", 32'(ir_pc), 32'd2);

    // Redirect while stalled
    ir_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'd7; tick("redir7");
    check("redir7_valid", 32'(ir_valid), 32'd0);
    check("redir7_pc", 32'(pc), 32'd7);
    redirect = 1'b0; ir_ready = 1'b1; tick("after_redir7");
    check("after_redir7_ir_pc", 32'(ir_pc), 32'd7);

    // Halt opcode at word 5, then restart
    redirect = 1'b1; redirect_pc = 8'd5; tick("redir5");
    redirect = 1'b0; tick("halt_fetch");
    check("halt_ir", 32'(ir), 32'hF000);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'd6);
    tick("halt_drain");
    check("halt_pc_stable", 32'(pc), 32'd6);
    start = 1'b1; tick("restart");
    start = 1'b0; tick("restart_fetch");
    check("restart_ir_pc", 32'(ir_pc), 32'd6);

`ifdef PC_BOUND_EN
    // Run off the end of memory, then recover via redirect
    redirect = 1'b1; redirect_pc = 8'd10; tick("redir10");
    redirect = 1'b0; tick("f10"); tick("f11"); tick("bound");
    check("bound_fault", 32'(fault), 32'd1);
    check("bound_pc", 32'(pc), 32'd12);
    check("bound_ir_pc", 32'(ir_pc), 32'd11);
    start = 1'b1; tick("fault_start");
    check("fault_start_ignored", 32'(fault), 32'd1);
    start = 1'b0; redirect = 1'b1; redirect_pc = 8'd0; tick("fault_exit");
    check("fault_exit_halted", 32'(halted), 32'd1);
    check("fault_exit_fault", 32'(fault), 32'd0);
    redirect = 1'b0;
`else
    // pc wraps past the top of the address space
    redirect = 1'b1; redirect_pc = 8'd254; tick("redir254");
    redirect = 1'b0; tick("f254"); tick("f255"); tick("wrap");
    check("wrap_ir_pc", 32'(ir_pc), 32'd0);
    check("wrap_pc", 32'(pc), 32'd1);
`endif

    // Random traffic over random program contents
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 9) == 0) w[15:12] = 4'hF;
      else if (w[15:12] == 4'hF) w[15:12] = 4'h0;
      mem[i] = w;
    end
    for (int i = 0; i < 400; i++) begin
      ir_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
`ifdef PC_BOUND_EN
      redirect_pc = 8'($urandom_range(0, 15));
`else
      redirect_pc = 8'($urandom_range(0, 255));
`endif
      start = ($urandom_range(0, 5) == 0);
      tick("rand");
    end

    // Asynchronous reset with an instruction pending
    load_linear();
    ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'd2; start = 1'b1; tick("pre_rst_a");
    redirect = 1'b0; tick("pre_rst_b");
    start = 1'b0; ir_ready = 1'b0; tick("pre_rst_c");
    check("pre_rst_valid", 32'(ir_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", 32'(ir_valid), 32'd0);
    check("async_rst_pc", 32'(pc), 32'd0);
    check("async_rst_halted", 32'(halted), 32'd1);
    check_model("async_rst");
    @(posedge clk); #1;
    check_model("rst_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8: program-counter width in bits.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 16: instruction word width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 12: number of valid instruction-memory words.
REQ-004 SHALL have parameter RESET_PC, default 0: pc value loaded at reset.
REQ-005 SHALL have parameter HALT_OPCODE, default 4'hF: value of instruction[INSTRUCTION_WIDTH-1 -: 4] that marks a halt.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port pc, output, PC_WIDTH bits: address to the instruction memory.
REQ-009 SHALL have port instruction, input, INSTRUCTION_WIDTH bits: combinational memory read data for pc, valid in the same cycle.
REQ-010 SHALL have port start, input, 1 bit: single-cycle pulse that resumes fetching.
REQ-011 SHALL have port redirect, input, 1 bit: load redirect_pc this cycle (branch or jump).
REQ-012 SHALL have port redirect_pc, input, PC_WIDTH bits: redirect target.
REQ-013 SHALL have port ir, output, INSTRUCTION_WIDTH bits: instruction register to decode.
REQ-014 SHALL have port ir_pc, output, PC_WIDTH bits: address from which ir was fetched.
REQ-015 SHALL have port ir_valid, output, 1 bit: ir holds an unconsumed instruction.
REQ-016 SHALL have port ir_ready, input, 1 bit: decode accepts ir this cycle.
REQ-017 SHALL have port halted, output, 1 bit: high while in state HALTED.
REQ-018 SHALL have port fault, output, 1 bit: high while in state FAULT.

Function
REQ-019 SHALL implement the states HALTED, RUN and FAULT; halted = (state==HALTED) and fault = (state==FAULT).
REQ-020 SHALL consume ir when ir_valid && ir_ready; while ir_valid && !ir_ready, ir, ir_pc and pc SHALL hold.
REQ-021 SHALL fetch in a cycle when state==RUN && !redirect && (!ir_valid || ir_ready); a fetch sets ir<=instruction, ir_pc<=pc, ir_valid<=1 and pc<=pc+1, modulo 2^PC_WIDTH.
REQ-022 SHALL clear ir_valid on the next edge when a cycle consumes ir and performs no fetch.
REQ-023 SHALL, on redirect in RUN or HALTED, set pc<=redirect_pc, clear ir_valid on the next edge and perform no fetch; an ir consumed in that same cycle still counts as accepted. Latency: the first fetch from the target occurs one cycle after redirect.
REQ-024 SHALL treat a fetched word with opcode field == HALT_OPCODE as a halt: it is loaded into ir normally, pc becomes pc+1, and state goes to HALTED.
REQ-025 SHALL move HALTED to RUN on start; if start and redirect occur in the same cycle, pc takes redirect_pc and state goes to RUN.
REQ-026 SHALL ignore start in RUN; in RUN, redirect takes priority over fetch.
REQ-027 SHALL, in FAULT, perform no fetch and ignore start; redirect SHALL load pc and move the state to HALTED. ir_valid SHALL still drain through the handshake.
REQ-028 SHALL keep ir, ir_pc, ir_valid and pc stable in HALTED, apart from draining ir_valid through the handshake.

Reset
REQ-029 SHALL, while rst_n=0, force state=HALTED, pc=RESET_PC, ir=0, ir_pc=0 and ir_valid=0, asynchronously and regardless of the clock.
REQ-030 SHALL abort any fetch or redirect in progress when reset asserts mid-operation; no partial update SHALL survive.

Configuration
REQ-031 SHALL, when macro PC_BOUND_EN is defined, turn an attempted fetch (REQ-021 conditions) with pc >= MEM_DEPTH into: no fetch, state<=FAULT, pc held.
REQ-032 SHALL, when PC_BOUND_EN is not defined, perform no bound check; pc wraps from 2^PC_WIDTH-1 to 0, and fault SHALL be constant 0.

Verification
REQ-033 SHALL cover: reset, then start with ir_ready=1 and memory words 0..3 = 0x1000..0x1003 -> ir_pc = 0,1,2,3 on consecutive cycles, ir_valid high from the second cycle after start.
REQ-034 SHALL cover: ir_ready=0 for 3 cycles with ir=0x1001 -> ir, ir_pc=1 and pc=2 held; the fetch resumes the cycle after ir_ready rises.
REQ-035 SHALL cover: redirect with redirect_pc=7 while ir_valid and ir_ready=0 -> ir_valid=0 next cycle, pc=7, then ir_pc=7.
REQ-036 SHALL cover: word 5 = 0xF000 -> ir=0xF000, halted=1, pc=6; a start pulse then produces the next fetch with ir_pc=6.
REQ-037 SHALL cover, with PC_BOUND_EN defined and MEM_DEPTH=12: sequential run to pc=12 -> fault=1, no fetch; a later redirect to 0 -> HALTED with fault=0.
REQ-038 SHALL cover: rst_n asserted mid-stream with ir_valid=1 -> ir_valid=0, pc=RESET_PC and halted=1 immediately, without waiting for a clock edge.
